// File: rtl/divisor_seq.sv
// Sequential restoring radix-2 divider, one quotient bit per clock.
// Optional two's-complement mode with divide-by-zero and overflow flags.
module divisor_seq #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] pr_q, pr_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dzp_q, dzp_d;
    logic             ovp_q, ovp_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dzf_q, dzf_d;
    logic             ovf_q, ovf_d;

    logic             a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] q_fix, r_fix;

    always_comb begin
        a_neg  = SIGNED && dividend[WIDTH-1];
        b_neg  = SIGNED && divisor[WIDTH-1];
        a_mag  = a_neg ? (~dividend + 1'b1) : dividend;
        b_mag  = b_neg ? (~divisor + 1'b1) : divisor;
        b_zero = (divisor == '0);

        // Partial remainder stays below the divisor, so the W-bit
        // modular difference is exact whenever the trial succeeds.
        shifted = {pr_q, dvd_q[WIDTH-1]};
        ge      = (shifted >= {1'b0, dsr_q});
        diff    = shifted[WIDTH-1:0] - dsr_q;

        q_fix = negq_q ? (~dvd_q + 1'b1) : dvd_q;
        r_fix = negr_q ? (~pr_q + 1'b1) : pr_q;

        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        pr_d    = pr_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dzp_d   = dzp_q;
        ovp_d   = ovp_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dzf_d   = dzf_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Divide-by-zero keeps the raw dividend for the remainder.
                    dvd_d   = b_zero ? dividend : a_mag;
                    dsr_d   = b_mag;
                    pr_d    = '0;
                    cnt_d   = '0;
                    negq_d  = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    dzp_d   = b_zero;
                    ovp_d   = SIGNED && (dividend == MIN_VAL) && (&divisor);
                    ready_d = 1'b0;
                    state_d = b_zero ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                pr_d  = ge ? diff : shifted[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                quo_d   = dzp_q ? '1 : q_fix;
                rem_d   = dzp_q ? dvd_q : r_fix;
                dzf_d   = dzp_q;
                ovf_d   = ovp_q;
                done_d  = 1'b1;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            pr_q    <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dzp_q   <= 1'b0;
            ovp_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dzf_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            pr_q    <= pr_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dzp_q   <= dzp_d;
            ovp_q   <= ovp_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dzf_q   <= dzf_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dzf_q;
    assign overflow    = SIGNED && ovf_q;

endmodule

// File: tb/tb_divisor_seq.sv
// Directed and model-based bench for divisor_seq in six builds:
// 8-bit, 4-bit and 16-bit, each unsigned and signed.
module tb_divisor_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a, b;
    logic        st [6];
    wire  [15:0] q [6];
    wire  [15:0] r [6];
    wire         rdy [6];
    wire         dn [6];
    wire         dz [6];
    wire         ov [6];

    int ncmp = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    function automatic int wof(input int g);
        return (g < 2) ? 8 : ((g < 4) ? 4 : 16);
    endfunction

    for (genvar g = 0; g < 6; g++) begin : g_dut
        localparam int W = (g < 2) ? 8 : ((g < 4) ? 4 : 16);
        logic [W-1:0] qq, rr;
        divisor_seq #(.WIDTH(W), .SIGNED(1'(g % 2))) u_dut (
            .clk(clk),
            .rst(rst),
            .start(st[g]),
            .dividend(a[W-1:0]),
            .divisor(b[W-1:0]),
            .ready(rdy[g]),
            .done(dn[g]),
            .quotient(qq),
            .remainder(rr),
            .div_by_zero(dz[g]),
            .overflow(ov[g])
        );
        assign q[g] = 16'(qq);
        assign r[g] = 16'(rr);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Independent reference using native integer division.
    task automatic model(input int w, input bit sg, input logic [15:0] x,
                         input logic [15:0] y, output logic [15:0] eq,
                         output logic [15:0] er, output logic edz,
                         output logic eov);
        longint mask, xs, ys;
        mask = (longint'(1) << w) - 1;
        xs = longint'(x) & mask;
        ys = longint'(y) & mask;
        if (sg && ((xs >> (w - 1)) & 1) == 1) xs = xs - (longint'(1) << w);
        if (sg && ((ys >> (w - 1)) & 1) == 1) ys = ys - (longint'(1) << w);
        edz = 1'b0;
        eov = 1'b0;
        if (ys == 0) begin
            eq  = 16'(mask);
            er  = 16'(xs & mask);
            edz = 1'b1;
        end else if (sg && xs == -(longint'(1) << (w - 1)) && ys == -1) begin
            eq  = 16'(longint'(1) << (w - 1));
            er  = '0;
            eov = 1'b1;
        end else begin
            eq = 16'((xs / ys) & mask);
            er = 16'((xs % ys) & mask);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_op(input int g, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] eq,
                          input logic [15:0] er, input logic edz,
                          input logic eov, input int pulse_at = 0);
        int n;
        bit seen;
        string tag;
        tag = $sformatf("g%0d %0h/%0h", g, x, y);
        chk({tag, " ready"}, 32'(rdy[g]), 1);
        a = x;
        b = y;
        st[g] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st[g] = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            if (pulse_at != 0 && n == pulse_at) begin
                chk({tag, " busy_ready"}, 32'(rdy[g]), 0);
                a = 16'd9;
                b = 16'd3;
                st[g] = 1'b1;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
            st[g] = 1'b0;
            if (dn[g]) seen = 1;
        end
        chk({tag, " latency"}, 32'(n), edz ? 1 : wof(g) + 1);
        chk({tag, " quotient"}, 32'(q[g]), 32'(eq));
        chk({tag, " remainder"}, 32'(r[g]), 32'(er));
        chk({tag, " div_by_zero"}, 32'(dz[g]), 32'(edz));
        chk({tag, " overflow"}, 32'(ov[g]), 32'(eov));
    endtask

    typedef struct {
        int          g;
        logic [15:0] x, y, q, r;
        logic        dz, ov;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [15:0] eq, er, x, y;
        logic edz, eov;

        tbl[0]  = '{0, 200, 7, 28, 4, 0, 0};
        tbl[1]  = '{0, 13, 0, 255, 13, 1, 0};
        tbl[2]  = '{0, 5, 9, 0, 5, 0, 0};
        tbl[3]  = '{0, 0, 3, 0, 0, 0, 0};
        tbl[4]  = '{0, 255, 16, 15, 15, 0, 0};
        tbl[5]  = '{0, 100, 10, 10, 0, 0, 0};
        tbl[6]  = '{1, 16'hF9, 2, 16'hFD, 16'hFF, 0, 0};
        tbl[7]  = '{1, 16'h07, 16'hFE, 16'hFD, 16'h01, 0, 0};
        tbl[8]  = '{1, 16'h80, 16'hFF, 16'h80, 16'h00, 0, 1};
        tbl[9]  = '{1, 16'h80, 16'h01, 16'h80, 16'h00, 0, 0};
        tbl[10] = '{1, 16'hF9, 16'h00, 16'hFF, 16'hF9, 1, 0};
        tbl[11] = '{1, 16'h80, 16'h02, 16'hC0, 16'h00, 0, 0};
        tbl[12] = '{1, 16'h7F, 16'h80, 16'h00, 16'h7F, 0, 0};
        tbl[13] = '{1, 16'h19, 16'h05, 16'h05, 16'h00, 0, 0};

        rst = 1'b1;
        a = '0;
        b = '0;
        for (int i = 0; i < 6; i++) st[i] = 1'b0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 6; g++) begin
            chk($sformatf("g%0d rst ready", g), 32'(rdy[g]), 1);
            chk($sformatf("g%0d rst done", g), 32'(dn[g]), 0);
            chk($sformatf("g%0d rst q", g), 32'(q[g]), 0);
            chk($sformatf("g%0d rst r", g), 32'(r[g]), 0);
            chk($sformatf("g%0d rst dz", g), 32'(dz[g]), 0);
            chk($sformatf("g%0d rst ov", g), 32'(ov[g]), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_op(tbl[i].g, tbl[i].x, tbl[i].y, tbl[i].q, tbl[i].r,
                   tbl[i].dz, tbl[i].ov);
        end

        // Result held and done a single-cycle pulse.
        run_op(0, 200, 7, 28, 4, 0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold done", 32'(dn[0]), 0);
            chk("hold q", 32'(q[0]), 28);
            chk("hold r", 32'(r[0]), 4);
        end

        // Start while busy ignored, then back-to-back in the done cycle.
        run_op(0, 200, 7, 28, 4, 0, 0, 3);
        run_op(0, 255, 16, 15, 15, 0, 0);

        // Reset four cycles into an operation.
        a = 16'd200;
        b = 16'd7;
        st[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst ready", 32'(rdy[0]), 1);
        chk("midrst done", 32'(dn[0]), 0);
        chk("midrst q", 32'(q[0]), 0);
        chk("midrst r", 32'(r[0]), 0);
        chk("midrst dz", 32'(dz[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("postrst no done", 32'(dn[0]), 0);
        end
        chk("postrst ready", 32'(rdy[0]), 1);
        run_op(0, 100, 10, 10, 0, 0, 0);

        // Exhaustive 4-bit, both modes.
        for (int g = 2; g < 4; g++) begin
            for (int i = 0; i < 256; i++) begin
                x = 16'(i % 16);
                y = 16'(i / 16);
                model(4, g % 2 == 1, x, y, eq, er, edz, eov);
                run_op(g, x, y, eq, er, edz, eov);
            end
        end

        // Random 16-bit, both modes, with forced corner operands.
        for (int g = 4; g < 6; g++) begin
            for (int i = 0; i < 1000; i++) begin
                x = 16'($urandom);
                y = 16'($urandom);
                if (i % 7 == 0) y = 16'($urandom_range(1, 15));
                if (i % 50 == 0) y = 16'h0000;
                if (i % 97 == 0) begin
                    x = 16'h8000;
                    y = 16'hFFFF;
                end
                model(16, g % 2 == 1, x, y, eq, er, edz, eov);
                run_op(g, x, y, eq, er, edz, eov);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
